// File: rtl/proc_pkg.sv
// Shared definitions for the ProjectB control unit:
// FSM state codes, opcodes, ALU selects and IR field positions.
package proc_pkg;

    typedef enum logic [3:0] {
        S_INIT   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_NOOP   = 4'd3,
        S_LOAD_A = 4'd4,
        S_LOAD_B = 4'd5,
        S_STORE  = 4'd6,
        S_ADD    = 4'd7,
        S_SUB    = 4'd8,
        S_HALT   = 4'd9
    } state_t;

    localparam logic [3:0] OP_NOOP  = 4'b0000;
    localparam logic [3:0] OP_STORE = 4'b0001;
    localparam logic [3:0] OP_LOAD  = 4'b0010;
    localparam logic [3:0] OP_ADD   = 4'b0011;
    localparam logic [3:0] OP_SUB   = 4'b0100;
    localparam logic [3:0] OP_HALT  = 4'b0101;

    localparam logic [2:0] ALU_PASS0 = 3'b000;
    localparam logic [2:0] ALU_ADD   = 3'b001;
    localparam logic [2:0] ALU_SUB   = 3'b010;
    localparam logic [2:0] ALU_PASSA = 3'b011;
    localparam logic [2:0] ALU_OR    = 3'b100;
    localparam logic [2:0] ALU_AND   = 3'b101;
    localparam logic [2:0] ALU_NOTA  = 3'b110;
    localparam logic [2:0] ALU_PASSB = 3'b111;

    localparam int OP_LSB      = 12;
    localparam int RA_LSB      = 8;
    localparam int RB_LSB      = 4;
    localparam int RD_LSB      = 0;
    localparam int LD_ADDR_LSB = 4;
    localparam int ST_ADDR_LSB = 0;

    typedef struct packed {
        logic       d_wr;
        logic       rf_s;
        logic       rf_w_en;
        logic [2:0] alu;
    } ctrl_t;

    function automatic ctrl_t state_ctrl(state_t s);
        ctrl_t c;
        c = '0;
        unique case (s)
            S_LOAD_B: begin
                c.rf_s    = 1'b1;
                c.rf_w_en = 1'b1;
            end
            S_STORE: c.d_wr = 1'b1;
            S_ADD: begin
                c.rf_w_en = 1'b1;
                c.alu     = ALU_ADD;
            end
            S_SUB: begin
                c.rf_w_en = 1'b1;
                c.alu     = ALU_SUB;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/program_counter.sv
// Program counter: synchronous clear, increment enable,
// wraps naturally at 2**PC_W.
module program_counter #(
    parameter int PC_W = 7
) (
    input  logic            i_clk,
    input  logic            i_clr,
    input  logic            i_inc,
    output logic [PC_W-1:0] o_pc
);

    logic [PC_W-1:0] r_pc;

    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_pc <= '0;
        end else if (i_inc) begin
            r_pc <= r_pc + PC_W'(1);
        end
    end

    assign o_pc = r_pc;

endmodule

// File: rtl/processor_control_unit.sv
// ProjectB control unit: fetch/decode/execute FSM, IR and PC,
// with registered Moore control outputs.
module processor_control_unit
    import proc_pkg::*;
#(
    parameter int PC_W      = 7,
    parameter int INSTR_W   = 16,
    parameter int RF_ADDR_W = 4,
    parameter int D_ADDR_W  = 8
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic [INSTR_W-1:0]   Instr_in,
    output logic [PC_W-1:0]      PC_out,
    output logic [INSTR_W-1:0]   IR_out,
    output logic [3:0]           State_out,
    output logic [D_ADDR_W-1:0]  D_addr,
    output logic                 D_wr,
    output logic                 RF_s,
    output logic [RF_ADDR_W-1:0] RF_W_addr,
    output logic                 RF_W_en,
    output logic [RF_ADDR_W-1:0] RF_Ra_addr,
    output logic [RF_ADDR_W-1:0] RF_Rb_addr,
    output logic [2:0]           ALU_s0
);

    state_t               r_state;
    state_t               w_next;
    logic [INSTR_W-1:0]   r_ir;
    ctrl_t                r_ctrl;
    logic [3:0]           w_op;
    logic                 w_fetch;

    assign w_op    = r_ir[OP_LSB +: 4];
    assign w_fetch = (r_state == S_FETCH);

    program_counter #(
        .PC_W (PC_W)
    ) u_pc (
        .i_clk (Clk),
        .i_clr (Reset),
        .i_inc (w_fetch),
        .o_pc  (PC_out)
    );

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_INIT:   w_next = S_FETCH;
            S_FETCH:  w_next = S_DECODE;
            S_DECODE: begin
                unique case (1'b1)
                    (w_op == OP_STORE): w_next = S_STORE;
                    (w_op == OP_LOAD):  w_next = S_LOAD_A;
                    (w_op == OP_ADD):   w_next = S_ADD;
                    (w_op == OP_SUB):   w_next = S_SUB;
                    (w_op == OP_HALT):  w_next = S_HALT;
                    default:            w_next = S_NOOP;
                endcase
            end
            S_LOAD_A: w_next = S_LOAD_B;
            S_NOOP,
            S_STORE,
            S_LOAD_B,
            S_ADD,
            S_SUB:    w_next = S_FETCH;
            S_HALT:   w_next = S_HALT;
            default:  w_next = S_INIT;
        endcase
    end

    // Controls are computed from the next state so they line up with it.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= S_INIT;
            r_ir    <= '0;
            r_ctrl  <= '0;
        end else begin
            r_state <= w_next;
            r_ctrl  <= state_ctrl(w_next);
            if (w_fetch) begin
                r_ir <= Instr_in;
            end
        end
    end

    assign IR_out     = r_ir;
    assign State_out  = r_state;
    assign D_wr       = r_ctrl.d_wr;
    assign RF_s       = r_ctrl.rf_s;
    assign RF_W_en    = r_ctrl.rf_w_en;
    assign ALU_s0     = r_ctrl.alu;
    assign RF_Ra_addr = r_ir[RA_LSB +: RF_ADDR_W];
    assign RF_Rb_addr = r_ir[RB_LSB +: RF_ADDR_W];
    assign RF_W_addr  = r_ir[RD_LSB +: RF_ADDR_W];
    assign D_addr     = (w_op == OP_LOAD) ? r_ir[LD_ADDR_LSB +: D_ADDR_W]
                                          : r_ir[ST_ADDR_LSB +: D_ADDR_W];

endmodule
